// File: rtl/logic_unit_arbiter_if.sv
// Request/response and shared-logic-unit signals of logic_unit_arbiter, grouped as one bundle.
// slave: arbiter side; master: requesters plus the shared logic unit.
interface logic_unit_arbiter_if #(
  parameter int DW = 8
);
  logic [3:0]      Req;
  logic [11:0]     Req_Op;
  logic [4*DW-1:0] Req_A;
  logic [4*DW-1:0] Req_B;
  logic [3:0]      Ack;
  logic [DW-1:0]   Result;
  logic [1:0]      Grant;
  logic            Busy;
  logic [DW-1:0]   LU_In1;
  logic [DW-1:0]   LU_In2;
  logic [2:0]      LU_Op;
  logic [DW-1:0]   LU_Out;

  modport slave (
    input  Req, Req_Op, Req_A, Req_B, LU_Out,
    output Ack, Result, Grant, Busy, LU_In1, LU_In2, LU_Op
  );

  modport master (
    output Req, Req_Op, Req_A, Req_B, LU_Out,
    input  Ack, Result, Grant, Busy, LU_In1, LU_In2, LU_Op
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Four-way arbiter sharing one 8-bit logic unit; LU_ARB_FIXED_PRIORITY_EN selects fixed priority (0 highest) instead of round-robin.
// Latency: request sampled in IDLE -> one-cycle Ack 3 cycles later; one op per 4 cycles.
// Backpressure: none; a requester holds Req until its Ack, requests are sampled only in IDLE.
module logic_unit_arbiter #(
  parameter int DW = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  logic_unit_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    grant_q, grant_d;
  logic [3:0]    ack_q, ack_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] in1_q, in1_d;
  logic [DW-1:0] in2_q, in2_d;
  logic [2:0]    op_q, op_d;

  logic          win_vld;
  logic [1:0]    win_idx;

`ifdef LU_ARB_FIXED_PRIORITY_EN
  // Descending scan so the lowest-numbered active requester is the last to overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.Req[i]) begin
        win_vld = 1'b1;
        win_idx = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] cand;

  // Descending offset scan: the smallest offset from the pointer wins, wrapping 3->0.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 2'd0;
    cand    = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr_q + 2'(i);
      if (bus.Req[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    ack_d    = 4'd0;
    result_d = result_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    op_d     = op_q;
`ifndef LU_ARB_FIXED_PRIORITY_EN
    ptr_d    = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          grant_d = win_idx;
          in1_d   = bus.Req_A[32'(win_idx) * DW +: DW];
          in2_d   = bus.Req_B[32'(win_idx) * DW +: DW];
          op_d    = bus.Req_Op[32'(win_idx) * 3 +: 3];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        result_d = bus.LU_Out;
        ack_d    = 4'd1 << grant_q;
        state_d  = RESP;
      end
      RESP: begin
`ifndef LU_ARB_FIXED_PRIORITY_EN
        ptr_d   = grant_q + 2'd1;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
      ack_q    <= 4'd0;
      result_q <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      op_q     <= 3'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      result_q <= result_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      op_q     <= op_d;
    end
  end

`ifndef LU_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr_q <= 2'd0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  assign bus.Ack    = ack_q;
  assign bus.Result = result_q;
  assign bus.Grant  = grant_q;
  assign bus.Busy   = (state_q != IDLE);
  assign bus.LU_In1 = in1_q;
  assign bus.LU_In2 = in2_q;
  assign bus.LU_Op  = op_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Bench for logic_unit_arbiter: transaction-timeline model compared every cycle plus directed literal checks.
module tb_logic_unit_arbiter;
  localparam int DW = 8;

  logic Clk = 1'b0;
  logic Rst_n;
  bit   check_en = 1'b0;

  int errs = 0;
  int checks = 0;

  logic_unit_arbiter_if #(.DW(DW)) bus ();

  logic_unit_arbiter #(.DW(DW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] lu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    lu_fn = a & b;
      3'd1:    lu_fn = a | b;
      3'd2:    lu_fn = a ^ b;
      3'd3:    lu_fn = ~(a & b);
      3'd4:    lu_fn = ~(a | b);
      3'd5:    lu_fn = ~(a ^ b);
      3'd6:    lu_fn = ~a;
      default: lu_fn = a;
    endcase
  endfunction

  assign bus.LU_Out = lu_fn(bus.LU_Op, bus.LU_In1, bus.LU_In2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a transaction occupies 4 cycles after being granted (grant, settle, capture, ack).
  int         m_phase = 0;
  int         m_ptr = 0;
  int         m_grant = 0;
  logic [7:0] m_in1 = '0, m_in2 = '0, m_result = '0;
  logic [2:0] m_op = '0;
  logic [3:0] m_ack = '0;
  bit         m_found;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      m_phase = 0; m_ptr = 0; m_grant = 0;
      m_in1 = '0; m_in2 = '0; m_op = '0; m_result = '0; m_ack = '0;
    end else begin
      case (m_phase)
        0: begin
          m_ack = '0;
          if (bus.Req != 4'd0) begin
            m_found = 1'b0;
            for (int off = 0; off < 4; off++) begin
              if (!m_found && bus.Req[(m_ptr + off) % 4]) begin
                m_found = 1'b1;
                m_grant = (m_ptr + off) % 4;
              end
            end
            m_in1 = bus.Req_A[m_grant*8 +: 8];
            m_in2 = bus.Req_B[m_grant*8 +: 8];
            m_op  = bus.Req_Op[m_grant*3 +: 3];
            m_phase = 1;
          end
        end
        1: m_phase = 2;
        2: begin
          m_result = lu_fn(m_op, m_in1, m_in2);
          m_ack    = 4'd1 << m_grant;
          m_phase  = 3;
        end
        default: begin
          m_ack = '0;
`ifndef LU_ARB_FIXED_PRIORITY_EN
          m_ptr = (m_grant + 1) % 4;
`endif
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge Clk) begin
    if (check_en) begin
      chk("cyc_ack",    32'(bus.Ack),    32'(m_ack));
      chk("cyc_result", 32'(bus.Result), 32'(m_result));
      chk("cyc_grant",  32'(bus.Grant),  32'(m_grant));
      chk("cyc_busy",   32'(bus.Busy),   32'(m_phase != 0));
      chk("cyc_in1",    32'(bus.LU_In1), 32'(m_in1));
      chk("cyc_in2",    32'(bus.LU_In2), 32'(m_in2));
      chk("cyc_op",     32'(bus.LU_Op),  32'(m_op));
    end
  end

  task automatic set_slot(input int idx, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.Req_Op[idx*3 +: 3] = op;
    bus.Req_A[idx*8 +: 8]  = a;
    bus.Req_B[idx*8 +: 8]  = b;
  endtask

  task automatic do_reset();
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    bus.Req = 4'd0;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    #1 Rst_n = 1'b1;
  endtask

  // Returns 1 ns after the edge on which Ack rises; cyc counts edges waited.
  task automatic wait_ack(output int cyc);
    cyc = 0;
    do begin
      @(posedge Clk);
      #1;
      cyc++;
    end while (bus.Ack == 4'd0 && cyc < 20);
    if (bus.Ack == 4'd0) begin
      checks++;
      errs++;
      $display("FAIL ack_timeout: no Ack within %0d cycles, required one", cyc);
    end
  endtask

  logic [7:0] rr_res   [4] = '{8'h12, 8'h05, 8'h30, 8'hAA};
  logic [7:0] sweep_exp[8] = '{8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'h5A, 8'hA5};

  initial begin
    int cyc;
    int idx;
    Rst_n = 1'b0;
    bus.Req = '0; bus.Req_Op = '0; bus.Req_A = '0; bus.Req_B = '0;
    @(posedge Clk);
    #1;
    chk("rst_ack",    32'(bus.Ack),    32'h0);
    chk("rst_result", 32'(bus.Result), 32'h0);
    chk("rst_busy",   32'(bus.Busy),   32'h0);
    chk("rst_grant",  32'(bus.Grant),  32'h0);
    check_en = 1'b1;
    @(negedge Clk);
    #1 Rst_n = 1'b1;

    // Single NAND request
    set_slot(0, 3'b011, 8'hF0, 8'hCC);
    bus.Req = 4'b0001;
    wait_ack(cyc);
    chk("single_lat",    32'(cyc),        32'd3);
    chk("single_ack",    32'(bus.Ack),    32'h1);
    chk("single_result", 32'(bus.Result), 32'h3F);
    chk("single_grant",  32'(bus.Grant),  32'h0);
    bus.Req = 4'b0000;

    // All four held, AND
    do_reset();
    set_slot(0, 3'b000, 8'hFF, 8'h12);
    set_slot(1, 3'b000, 8'h0F, 8'h35);
    set_slot(2, 3'b000, 8'hF0, 8'h35);
    set_slot(3, 3'b000, 8'hAA, 8'hFF);
    bus.Req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(cyc);
`ifdef LU_ARB_FIXED_PRIORITY_EN
      idx = 0;
`else
      idx = n % 4;
`endif
      chk("all_ack",    32'(bus.Ack),    32'(4'd1 << idx));
      chk("all_grant",  32'(bus.Grant),  32'(idx));
      chk("all_result", 32'(bus.Result), 32'(rr_res[idx]));
      chk("all_gap",    32'(cyc),        (n == 0) ? 32'd3 : 32'd4);
    end
    bus.Req = 4'b0000;

    // Req=1010 from pointer 0: 1 then 3
    do_reset();
    set_slot(1, 3'b001, 8'h3C, 8'hF0);
    set_slot(3, 3'b010, 8'h81, 8'h18);
    bus.Req = 4'b1010;
    wait_ack(cyc);
    chk("skip_ack1",    32'(bus.Ack),    32'h2);
    chk("skip_grant1",  32'(bus.Grant),  32'h1);
    chk("skip_result1", 32'(bus.Result), 32'hFC);
    bus.Req = 4'b1000;
    wait_ack(cyc);
    chk("skip_ack3",    32'(bus.Ack),    32'h8);
    chk("skip_grant3",  32'(bus.Grant),  32'h3);
    chk("skip_result3", 32'(bus.Result), 32'h99);
    chk("skip_gap",     32'(cyc),        32'd4);
    bus.Req = 4'b0000;

    // Operand change while busy is ignored
    do_reset();
    set_slot(0, 3'b000, 8'h5A, 8'hFF);
    bus.Req = 4'b0001;
    @(posedge Clk);
    #2 set_slot(0, 3'b000, 8'h00, 8'h00);
    wait_ack(cyc);
    chk("latch_ack",    32'(bus.Ack),    32'h1);
    chk("latch_result", 32'(bus.Result), 32'h5A);
    bus.Req = 4'b0000;

    // Opcode sweep on requester 2
    for (int op = 0; op < 8; op++) begin
      set_slot(2, 3'(op), 8'hA5, 8'h0F);
      bus.Req = 4'b0100;
      wait_ack(cyc);
      chk("sweep_ack",    32'(bus.Ack),    32'h4);
      chk("sweep_result", 32'(bus.Result), 32'(sweep_exp[op]));
      bus.Req = 4'b0000;
    end

    // Reset during CAPTURE
    do_reset();
    set_slot(2, 3'b010, 8'h3C, 8'h0F);
    bus.Req = 4'b0100;
    @(posedge Clk);
    @(posedge Clk);
    #2 Rst_n = 1'b0;
    #1;
    chk("abort_ack",    32'(bus.Ack),    32'h0);
    chk("abort_result", 32'(bus.Result), 32'h0);
    chk("abort_grant",  32'(bus.Grant),  32'h0);
    chk("abort_busy",   32'(bus.Busy),   32'h0);
    chk("abort_in1",    32'(bus.LU_In1), 32'h0);
    chk("abort_in2",    32'(bus.LU_In2), 32'h0);
    chk("abort_op",     32'(bus.LU_Op),  32'h0);
    @(posedge Clk);
    #1 chk("abort_noack", 32'(bus.Ack), 32'h0);
    @(negedge Clk);
    #1 Rst_n = 1'b1;
    wait_ack(cyc);
    chk("rearb_lat",    32'(cyc),        32'd3);
    chk("rearb_ack",    32'(bus.Ack),    32'h4);
    chk("rearb_grant",  32'(bus.Grant),  32'h2);
    chk("rearb_result", 32'(bus.Result), 32'h33);
    bus.Req = 4'b0000;

    repeat (3) @(posedge Clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
